// File: rtl/spi_pkg.sv
// Shared widths, word type and master state encoding for the SPI link.
package spi_pkg;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    M_IDLE,
    M_LOAD,
    M_SHIFT,
    M_WRITE,
    M_GAP,
    M_STOP
  } mst_state_t;
endpackage

// File: rtl/spi_master.sv
// SPI mode-0 master: walks its RAM and swaps one 24-bit word per frame with the slave.
//   state   | meaning
//   M_IDLE  | post-reset, address cleared
//   M_LOAD  | fetch word, drop csn, present MSB
//   M_SHIFT | toggle sck every CLK_DIV clk, 24 bits
//   M_WRITE | store received word, raise csn
//   M_GAP   | csn-high gap of 2*CLK_DIV clk
//   M_STOP  | all words done, idle until reset
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  output logic sck,
  output logic csn,
  output logic mo,
  input  logic mi
);
  localparam int TW = 16;
  localparam logic [TW-1:0] DIV_LD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(2 * CLK_DIV - 1);

  mst_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr;
  word_t             tx, rx, rd_data;
  logic [4:0]        bitcnt;
  logic [TW-1:0]     tmr;
  logic              tc, last_fall, we;

  assign tc        = (tmr == '0);
  assign last_fall = (state == M_SHIFT) && tc && sck && (bitcnt == 5'(DATA_W));
  assign we        = (state == M_WRITE);

  spi_ram ram_inst (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (rx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state <= M_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      M_IDLE:  state_nxt = M_LOAD;
      M_LOAD:  state_nxt = M_SHIFT;
      M_SHIFT: if (last_fall) state_nxt = M_WRITE;
      M_WRITE: state_nxt = M_GAP;
      M_GAP:   if (tc) state_nxt = (addr == ADDR_W'(DEPTH - 1)) ? M_STOP : M_LOAD;
      M_STOP:  state_nxt = M_STOP;
      default: state_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sck    <= 1'b0;
      csn    <= 1'b1;
      mo     <= 1'b0;
      addr   <= '0;
      tx     <= '0;
      rx     <= '0;
      bitcnt <= '0;
      tmr    <= '0;
    end else begin
      case (state)
        M_IDLE: addr <= '0;
        M_LOAD: begin
          tx     <= rd_data;
          rx     <= '0;
          csn    <= 1'b0;
          mo     <= rd_data[DATA_W-1];
          bitcnt <= '0;
          tmr    <= DIV_LD;
        end
        M_SHIFT: begin
          if (tc) begin
            tmr <= DIV_LD;
            sck <= ~sck;
            if (!sck) begin
              rx     <= {rx[DATA_W-2:0], mi};
              bitcnt <= bitcnt + 5'd1;
            end else begin
              tx <= {tx[DATA_W-2:0], 1'b0};
              mo <= tx[DATA_W-2];
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        M_WRITE: begin
          csn <= 1'b1;
          mo  <= 1'b0;
          tmr <= GAP_LD;
        end
        M_GAP: begin
          if (tc) begin
            if (addr != ADDR_W'(DEPTH - 1)) addr <= addr + ADDR_W'(1);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/spi_ram.sv
// 32 x 24 word RAM: synchronous write, asynchronous read, contents survive reset.
module spi_ram
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             wdata,
  output word_t             rdata
);
  word_t mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples sck/csn/si on clk and swaps one RAM word per complete frame.
module spi_slave
  import spi_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic sck,
  input  logic csn,
  input  logic si,
  output logic so
);
  logic [1:0]        sck_s, csn_s, si_s;
  logic              sck_d, csn_d, so_q;
  logic              sck_rise, sck_fall, csn_fall, csn_rise, we;
  logic [ADDR_W-1:0] saddr;
  logic [4:0]        bitcnt;
  word_t             tx, rx, rd_data;

  assign sck_rise = sck_s[1] & ~sck_d;
  assign sck_fall = ~sck_s[1] & sck_d;
  assign csn_fall = ~csn_s[1] & csn_d;
  assign csn_rise = csn_s[1] & ~csn_d;
  assign we       = csn_rise && (bitcnt == 5'(DATA_W));

  // Gate with the raw select so MISO is low the moment csn goes high.
  assign so = so_q & ~csn;

  spi_ram ram_inst (
    .clk   (clk),
    .we    (we),
    .addr  (saddr),
    .wdata (rx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sck_s  <= 2'b00;
      csn_s  <= 2'b11;
      si_s   <= 2'b00;
      sck_d  <= 1'b0;
      csn_d  <= 1'b1;
      so_q   <= 1'b0;
      saddr  <= '0;
      bitcnt <= '0;
      tx     <= '0;
      rx     <= '0;
    end else begin
      sck_s <= {sck_s[0], sck};
      csn_s <= {csn_s[0], csn};
      si_s  <= {si_s[0], si};
      sck_d <= sck_s[1];
      csn_d <= csn_s[1];
      if (csn_fall) begin
        tx     <= rd_data;
        so_q   <= rd_data[DATA_W-1];
        bitcnt <= '0;
      end else if (csn_rise) begin
        so_q <= 1'b0;
        if (we) saddr <= saddr + ADDR_W'(1);
      end else if (!csn_s[1]) begin
        if (sck_rise) begin
          rx     <= {rx[DATA_W-2:0], si_s[1]};
          bitcnt <= bitcnt + 5'd1;
        end else if (sck_fall) begin
          tx   <= {tx[DATA_W-2:0], 1'b0};
          so_q <= tx[DATA_W-2];
        end
      end
    end
  end
endmodule

// File: rtl/spi_master_slave.sv
// Point-to-point SPI link: master and slave wired back to back, bus pins exposed for observation.
module spi_master_slave #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  output logic sck,
  output logic csn,
  output logic mo,
  output logic so
);
  spi_master #(.CLK_DIV(CLK_DIV)) master_inst (
    .clk  (clk),
    .rstn (rstn),
    .sck  (sck),
    .csn  (csn),
    .mo   (mo),
    .mi   (so)
  );

  spi_slave slave_inst (
    .clk  (clk),
    .rstn (rstn),
    .sck  (sck),
    .csn  (csn),
    .si   (mo),
    .so   (so)
  );
endmodule

// File: tb/tb_spi_master_slave.sv
// Bench for spi_master_slave: word-swap reference model plus bus waveform monitors.
module tb_spi_master_slave;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst4, rst8;
  logic sck4, csn4, mo4, so4;
  logic sck8, csn8, mo8, so8;

  always #5 clk = ~clk;

  spi_master_slave #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rstn(rst4), .sck(sck4), .csn(csn4), .mo(mo4), .so(so4)
  );
  spi_master_slave #(.CLK_DIV(8)) dut8 (
    .clk(clk), .rstn(rst8), .sck(sck8), .csn(csn8), .mo(mo8), .so(so8)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  word_t m4 [DEPTH];
  word_t s4 [DEPTH];
  word_t m8 [DEPTH];
  word_t s8 [DEPTH];

  // frame monitor for dut4
  int    r4 = 0, f4_frames = 0, f4_rises = 0, act4 = 0;
  word_t w4 = '0, f4_mo = '0;
  time   t4a = 0, t4b = 0, f4_per = 0;
  logic  sck4_p = 1'b0, csn4_p = 1'b1;
  always @(negedge clk) begin
    if (rst4 && (sck4 !== sck4_p)) act4++;
    if (csn4_p && csn4 === 1'b0) begin r4 = 0; w4 = '0; end
    if (!sck4_p && sck4 === 1'b1 && csn4 === 1'b0) begin
      w4 = {w4[DATA_W-2:0], mo4};
      r4++;
      if (r4 == 1) t4a = $time;
      if (r4 == 2) t4b = $time;
    end
    if (!csn4_p && csn4 === 1'b1) begin
      f4_rises = r4; f4_mo = w4; f4_per = t4b - t4a; f4_frames++;
    end
    sck4_p = sck4; csn4_p = csn4;
  end

  // frame monitor for dut8
  int   r8 = 0, f8_frames = 0;
  time  t8a = 0, t8b = 0, f8_per = 0;
  logic sck8_p = 1'b0, csn8_p = 1'b1;
  always @(negedge clk) begin
    if (csn8_p && csn8 === 1'b0) r8 = 0;
    if (!sck8_p && sck8 === 1'b1 && csn8 === 1'b0) begin
      r8++;
      if (r8 == 1) t8a = $time;
      if (r8 == 2) t8b = $time;
    end
    if (!csn8_p && csn8 === 1'b1) begin
      if (f8_frames == 0) f8_per = t8b - t8a;
      f8_frames++;
    end
    sck8_p = sck8; csn8_p = csn8;
  end

  task automatic wait_f4(input int target, input int budget);
    int cyc = 0;
    while (f4_frames < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("frame4_wait", 32'(f4_frames >= target), 32'd1);
  endtask

  initial begin
    int    cyc, base, low_cnt;
    word_t tmp;
    rst4 = 1'b1;
    rst8 = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      m4[i] = '0;
      s4[i] = '0;
    end
    m4[0] = 24'hABCDEF;
    s4[0] = 24'hFEDCBA;
    m4[1] = 24'($urandom);
    s4[1] = 24'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      dut4.master_inst.ram_inst.mem[i] = m4[i];
      dut4.slave_inst.ram_inst.mem[i]  = s4[i];
    end

    repeat (20) @(negedge clk);
    chk("rst_sck", 32'(sck4), 32'd0);
    chk("rst_csn", 32'(csn4), 32'd1);
    chk("rst_mo", 32'(mo4), 32'd0);
    chk("rst_so", 32'(so4), 32'd0);
    chk("rst_sck_activity", 32'(act4), 32'd0);

    rst4 = 1'b0;
    cyc = 0;
    while (csn4 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("csn_fall_latency_le3", 32'(cyc <= 3), 32'd1);

    wait_f4(1, 1000);
    repeat (10) @(negedge clk);
    chk("f0_rises", 32'(f4_rises), 32'd24);
    chk("f0_mo_bits", 32'(f4_mo), 32'(m4[0]));
    chk("f0_sck_period_ns", 32'(f4_per), 32'd80);
    tmp = m4[0]; m4[0] = s4[0]; s4[0] = tmp;
    chk("f0_master_mem0", 32'(dut4.master_inst.ram_inst.mem[0]), 32'(m4[0]));
    chk("f0_slave_mem0", 32'(dut4.slave_inst.ram_inst.mem[0]), 32'(s4[0]));

    // abort frame 1 during bit 10
    cyc = 0;
    while (!(csn4 === 1'b0 && r4 == 10) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach_bit10", 32'(cyc < 2000), 32'd1);
    @(posedge clk);
    #2 rst4 = 1'b1;
    #1;
    chk("abort_sck", 32'(sck4), 32'd0);
    chk("abort_csn", 32'(csn4), 32'd1);
    chk("abort_mo", 32'(mo4), 32'd0);
    chk("abort_so", 32'(so4), 32'd0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort_master_mem%0d", i), 32'(dut4.master_inst.ram_inst.mem[i]), 32'(m4[i]));
      chk($sformatf("abort_slave_mem%0d", i), 32'(dut4.slave_inst.ram_inst.mem[i]), 32'(s4[i]));
    end

    for (int i = 0; i < DEPTH; i++) begin
      m4[i] = 24'(i);
      s4[i] = 24'h800000 | 24'(i);
      dut4.master_inst.ram_inst.mem[i] = m4[i];
      dut4.slave_inst.ram_inst.mem[i]  = s4[i];
    end
    base = f4_frames;
    @(negedge clk);
    rst4 = 1'b0;
    cyc = 0;
    while (csn4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("restart_addr", 32'(dut4.master_inst.addr), 32'd0);

    for (int k = 0; k < DEPTH; k++) begin
      wait_f4(base + k + 1, 1000);
      chk($sformatf("run_rises_f%0d", k), 32'(f4_rises), 32'd24);
      chk($sformatf("run_mo_f%0d", k), 32'(f4_mo), 32'(m4[k]));
      tmp = m4[k]; m4[k] = s4[k]; s4[k] = tmp;
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("run_master_mem%0d", i), 32'(dut4.master_inst.ram_inst.mem[i]), 32'(m4[i]));
      chk($sformatf("run_slave_mem%0d", i), 32'(dut4.slave_inst.ram_inst.mem[i]), 32'(s4[i]));
    end
    low_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (csn4 !== 1'b1 || sck4 !== 1'b0) low_cnt++;
    end
    chk("stop_csn_high", 32'(low_cnt), 32'd0);
    chk("stop_saddr_wrapped", 32'(dut4.slave_inst.saddr), 32'd0);

    // CLK_DIV = 8 run with random words
    for (int i = 0; i < DEPTH; i++) begin
      m8[i] = 24'($urandom);
      s8[i] = 24'($urandom);
      dut8.master_inst.ram_inst.mem[i] = m8[i];
      dut8.slave_inst.ram_inst.mem[i]  = s8[i];
    end
    @(negedge clk);
    rst8 = 1'b0;
    cyc = 0;
    while (f8_frames < DEPTH && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("div8_frames_done", 32'(f8_frames), 32'(DEPTH));
    chk("div8_sck_period_ns", 32'(f8_per), 32'd160);
    repeat (20) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("div8_master_mem%0d", i), 32'(dut8.master_inst.ram_inst.mem[i]), 32'(s8[i]));
      chk($sformatf("div8_slave_mem%0d", i), 32'(dut8.slave_inst.ram_inst.mem[i]), 32'(m8[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
